rggen_axi4lite_bridge_pipelined: RTL



---
 rtl/rggen_axi4lite_bridge_pipelined.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rggen_axi4lite_bridge_pipelined.sv
// AXI4-Lite slave to rggen bus bridge with per-direction response queues.
// Write/read grant is arbitrated, then held stable until the bus accepts it.
module rggen_axi4lite_bridge_pipelined_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign o_full  = count == CW'(DEPTH);
    assign o_empty = count == '0;
    assign pop     = i_pop && !o_empty;
    assign push    = i_push && (!o_full || pop);
    assign o_data  = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end
endmodule

module rggen_axi4lite_bridge_pipelined #(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int OUTSTANDING   = 2,
    parameter int ARBITRATION   = 0,
    localparam int IW = (ID_WIDTH > 0) ? ID_WIDTH : 1,
    localparam int SW = BUS_WIDTH / 8
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_awvalid,
    output logic                     o_awready,
    input  logic [IW-1:0]            i_awid,
    input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
    input  logic                     i_wvalid,
    output logic                     o_wready,
    input  logic [BUS_WIDTH-1:0]     i_wdata,
    input  logic [SW-1:0]            i_wstrb,
    output logic                     o_bvalid,
    input  logic                     i_bready,
    output logic [IW-1:0]            o_bid,
    output logic [1:0]               o_bresp,
    input  logic                     i_arvalid,
    output logic                     o_arready,
    input  logic [IW-1:0]            i_arid,
    input  logic [ADDRESS_WIDTH-1:0] i_araddr,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic [IW-1:0]            o_rid,
    output logic [1:0]               o_rresp,
    output logic [BUS_WIDTH-1:0]     o_rdata,
    output logic                     o_bus_valid,
    output logic [1:0]               o_bus_access,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [BUS_WIDTH-1:0]     o_bus_write_data,
    output logic [SW-1:0]            o_bus_strobe,
    input  logic                     i_bus_ready,
    input  logic [1:0]               i_bus_status,
    input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);
    localparam logic [1:0] RGGEN_READ  = 2'b10;
    localparam logic [1:0] RGGEN_WRITE = 2'b11;
    localparam int BW_E = IW + 2;
    localparam int RW_E = IW + 2 + BUS_WIDTH;

    logic            locked;
    logic            lock_read;
    logic            last_read;
    logic            write_cand;
    logic            read_cand;
    logic            grant_read;
    logic            bus_valid;
    logic            handshake;
    logic            b_full;
    logic            b_empty;
    logic            r_full;
    logic            r_empty;
    logic [IW-1:0]   awid;
    logic [IW-1:0]   arid;
    logic [BW_E-1:0] b_entry;
    logic [RW_E-1:0] r_entry;

    assign awid = (ID_WIDTH > 0) ? i_awid : '0;
    assign arid = (ID_WIDTH > 0) ? i_arid : '0;

    assign write_cand = i_awvalid && i_wvalid && !b_full;
    assign read_cand  = i_arvalid && !r_full;
    assign bus_valid  = locked || write_cand || read_cand;
    assign handshake  = bus_valid && i_bus_ready;

    always_comb begin
        grant_read = 1'b0;
        if (locked) begin
            grant_read = lock_read;
        end else if (read_cand && !write_cand) begin
            grant_read = 1'b1;
        end else if (read_cand && write_cand) begin
            if (ARBITRATION == 1) begin
                grant_read = 1'b1;
            end else if (ARBITRATION == 2) begin
                grant_read = !last_read;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            locked    <= 1'b0;
            lock_read <= 1'b0;
            last_read <= 1'b1;
        end else begin
            locked    <= bus_valid && !i_bus_ready;
            lock_read <= grant_read;
            if (handshake) begin
                last_read <= grant_read;
            end
        end
    end

    assign o_bus_valid      = bus_valid;
    assign o_bus_access     = grant_read ? RGGEN_READ : RGGEN_WRITE;
    assign o_bus_address    = grant_read ? i_araddr : i_awaddr;
    assign o_bus_write_data = grant_read ? '0 : i_wdata;
    assign o_bus_strobe     = grant_read ? '0 : i_wstrb;

    assign o_awready = handshake && !grant_read;
    assign o_wready  = handshake && !grant_read;
    assign o_arready = handshake && grant_read;

    rggen_axi4lite_bridge_pipelined_queue #(
        .WIDTH (BW_E),
        .DEPTH (OUTSTANDING)
    ) u_b_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (handshake && !grant_read),
        .i_data  ({awid, i_bus_status}),
        .i_pop   (i_bready),
        .o_full  (b_full),
        .o_empty (b_empty),
        .o_data  (b_entry)
    );

    rggen_axi4lite_bridge_pipelined_queue #(
        .WIDTH (RW_E),
        .DEPTH (OUTSTANDING)
    ) u_r_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (handshake && grant_read),
        .i_data  ({arid, i_bus_status, i_bus_read_data}),
        .i_pop   (i_rready),
        .o_full  (r_full),
        .o_empty (r_empty),
        .o_data  (r_entry)
    );

    assign o_bvalid = !b_empty;
    assign o_bid    = b_entry[BW_E-1-:IW];
    assign o_bresp  = b_entry[1:0];
    assign o_rvalid = !r_empty;
    assign o_rid    = r_entry[RW_E-1-:IW];
    assign o_rresp  = r_entry[BUS_WIDTH+:2];
    assign o_rdata  = r_entry[BUS_WIDTH-1:0];
endmodule
